// File: rtl/accumulator_bank_if.sv
// Request/response bundle between the systolic column and the accumulator bank.
// The column side (master) drives accumulate, preload, read and bulk-clear
// requests; the bank (slave) returns registered read data and status flags.
interface accumulator_bank_if #(
    parameter int DATA_W = 45,
    parameter int COMP_W = 14,
    parameter int ADDR_W = 3
);
    // accumulate request
    logic                     acc_wr_en;
    logic [ADDR_W-1:0]        acc_wr_addr;
    logic signed [DATA_W-1:0] psum_in;
    // preload request
    logic                     comp_wr_en;
    logic [ADDR_W-1:0]        comp_wr_addr;
    logic signed [COMP_W-1:0] comp_in;
    // read request
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_clear;
    // bulk clear
    logic                     clr_all;
    // response / status
    logic                     rd_valid;
    logic signed [DATA_W-1:0] rd_data;
    logic                     busy;
    logic                     sat_flag;
    logic                     drop_flag;

    modport master (
        output acc_wr_en, acc_wr_addr, psum_in,
        output comp_wr_en, comp_wr_addr, comp_in,
        output rd_en, rd_addr, rd_clear, clr_all,
        input  rd_valid, rd_data, busy, sat_flag, drop_flag
    );

    modport slave (
        input  acc_wr_en, acc_wr_addr, psum_in,
        input  comp_wr_en, comp_wr_addr, comp_in,
        input  rd_en, rd_addr, rd_clear, clr_all,
        output rd_valid, rd_data, busy, sat_flag, drop_flag
    );
endinterface

// File: rtl/accumulator_bank.sv
// Bank of DEPTH signed accumulators below one systolic-array column.
// Each entry can be preloaded with a sign-extended compensation value,
// accumulated with saturation or wrap, read with optional clear, and swept
// to zero by a DEPTH-cycle bulk-clear sequencer.

// One accumulator entry. Priority at an edge: preload > accumulate > clear.
// A clear that coincides with an accumulate makes the add start from zero.
module accumulator_bank_entry #(
    parameter int DATA_W   = 45,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_hit,
    input  logic              comp_hit,
    input  logic              clr_hit,
    input  logic [DATA_W-1:0] psum,
    input  logic [DATA_W-1:0] comp_ext,
    output logic [DATA_W-1:0] value,
    output logic              ovf
);
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] base;
    logic [DATA_W:0]   sum;
    logic              ovf_raw;
    logic [DATA_W-1:0] nxt;

    // One-bit-wider add; the two top bits disagree exactly when the result is out of range
    always_comb begin
        base    = clr_hit ? '0 : value;
        sum     = {base[DATA_W-1], base} + {psum[DATA_W-1], psum};
        ovf_raw = sum[DATA_W] ^ sum[DATA_W-1];
        nxt     = sum[DATA_W-1:0];
        if (ovf_raw && (SATURATE != 0))
            nxt = sum[DATA_W] ? MIN_V : MAX_V;
        // a psum discarded by a colliding preload never raises the flag
        ovf     = acc_hit & ~comp_hit & ovf_raw;
    end

    // Entry storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        value <= '0;
        else if (comp_hit) value <= comp_ext;
        else if (acc_hit)  value <= nxt;
        else if (clr_hit)  value <= '0;
    end
endmodule

module accumulator_bank #(
    parameter int DATA_W   = 45,
    parameter int COMP_W   = 14,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    accumulator_bank_if.slave  bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                        state_q;
    logic [ADDR_W-1:0]             cnt_q;
    logic                          busy_q;
    logic                          sat_q;
    logic                          drop_q;
    logic                          rd_valid_q;
    logic [DATA_W-1:0]             rd_data_q;

    logic [DEPTH-1:0][DATA_W-1:0]  entry_q;
    logic [DEPTH-1:0]              ovf;
    logic [DATA_W-1:0]             comp_ext;
    logic                          idle;
    logic                          sweep_last;
    logic                          sat_ev;
    logic                          drop_ev;

    assign idle       = (state_q == IDLE);
    assign sweep_last = !idle && (cnt_q == ADDR_W'(DEPTH-1));
    assign comp_ext   = DATA_W'($signed(bus.comp_in));
    assign sat_ev     = |ovf;
    // writes arriving while the sweep owns the array are lost, not deferred
    assign drop_ev    = !idle && (bus.acc_wr_en || bus.comp_wr_en);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic acc_hit, comp_hit, clr_hit;
        assign acc_hit  = idle && bus.acc_wr_en  && (bus.acc_wr_addr  == ADDR_W'(i));
        assign comp_hit = idle && bus.comp_wr_en && (bus.comp_wr_addr == ADDR_W'(i));
        assign clr_hit  = (bus.rd_en && bus.rd_clear && (bus.rd_addr == ADDR_W'(i)))
                        || (!idle && (cnt_q == ADDR_W'(i)));

        accumulator_bank_entry #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .acc_hit  (acc_hit),
            .comp_hit (comp_hit),
            .clr_hit  (clr_hit),
            .psum     (bus.psum_in),
            .comp_ext (comp_ext),
            .value    (entry_q[i]),
            .ovf      (ovf[i])
        );
    end

    // Bulk-clear sequencer: one entry per cycle, DEPTH cycles, busy registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clr_all) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags; the sweep's last edge resets them but a same-cycle event survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q  <= 1'b0;
            drop_q <= 1'b0;
        end else if (sweep_last) begin
            sat_q  <= sat_ev;
            drop_q <= drop_ev;
        end else begin
            sat_q  <= sat_q  | sat_ev;
            drop_q <= drop_q | drop_ev;
        end
    end

    // Registered read port: samples pre-write contents, rd_data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= entry_q[bus.rd_addr];
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.sat_flag  = sat_q;
    assign bus.drop_flag = drop_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// Drives three banks with one stimulus stream: 45-bit saturating, 8-bit
// saturating and 8-bit wrapping. A per-bank integer model tracks entries,
// flags and the sweep; directed scenarios add fixed expected values.
module tb_accumulator_bank;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        acc_en, comp_en, rd_en, rd_clr, clr_all;
    logic [2:0]  acc_a, comp_a, rd_a;
    logic [63:0] psum_v, comp_v;

    accumulator_bank_if #(.DATA_W(45), .COMP_W(14), .ADDR_W(3)) if_b ();
    accumulator_bank_if #(.DATA_W(8),  .COMP_W(8),  .ADDR_W(3)) if_s ();
    accumulator_bank_if #(.DATA_W(8),  .COMP_W(8),  .ADDR_W(3)) if_w ();

    assign if_b.acc_wr_en = acc_en;  assign if_s.acc_wr_en = acc_en;  assign if_w.acc_wr_en = acc_en;
    assign if_b.acc_wr_addr = acc_a; assign if_s.acc_wr_addr = acc_a; assign if_w.acc_wr_addr = acc_a;
    assign if_b.psum_in = psum_v[44:0]; assign if_s.psum_in = psum_v[7:0]; assign if_w.psum_in = psum_v[7:0];
    assign if_b.comp_wr_en = comp_en;  assign if_s.comp_wr_en = comp_en;  assign if_w.comp_wr_en = comp_en;
    assign if_b.comp_wr_addr = comp_a; assign if_s.comp_wr_addr = comp_a; assign if_w.comp_wr_addr = comp_a;
    assign if_b.comp_in = comp_v[13:0]; assign if_s.comp_in = comp_v[7:0]; assign if_w.comp_in = comp_v[7:0];
    assign if_b.rd_en = rd_en;    assign if_s.rd_en = rd_en;    assign if_w.rd_en = rd_en;
    assign if_b.rd_addr = rd_a;   assign if_s.rd_addr = rd_a;   assign if_w.rd_addr = rd_a;
    assign if_b.rd_clear = rd_clr; assign if_s.rd_clear = rd_clr; assign if_w.rd_clear = rd_clr;
    assign if_b.clr_all = clr_all; assign if_s.clr_all = clr_all; assign if_w.clr_all = clr_all;

    accumulator_bank #(.DATA_W(45), .COMP_W(14), .DEPTH(8), .ADDR_W(3), .SATURATE(1))
        u_big (.clk(clk), .rst_n(rst_n), .bus(if_b));
    accumulator_bank #(.DATA_W(8), .COMP_W(8), .DEPTH(8), .ADDR_W(3), .SATURATE(1))
        u_sat8 (.clk(clk), .rst_n(rst_n), .bus(if_s));
    accumulator_bank #(.DATA_W(8), .COMP_W(8), .DEPTH(8), .ADDR_W(3), .SATURATE(0))
        u_wrap8 (.clk(clk), .rst_n(rst_n), .bus(if_w));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     w_d[3]  = '{45, 8, 8};
    int     cw_d[3] = '{14, 8, 8};
    bit     sat_d[3] = '{1'b1, 1'b1, 1'b0};
    longint mem[3][8];
    bit     m_busy[3], m_sat[3], m_drop[3], m_rdv[3];
    longint m_rdd[3];
    int     m_cnt[3];

    function automatic longint sx(input logic [63:0] v, input int w);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r -= (longint'(1) << w);
        return r;
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < 8; i++) mem[d][i] = 0;
        m_busy[d] = 0; m_sat[d] = 0; m_drop[d] = 0; m_rdv[d] = 0;
        m_rdd[d] = 0;  m_cnt[d] = 0;
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            longint old[8];
            longint base, s, maxv, minv;
            bit sat_ev, drop_ev;
            if (!rst_n) begin model_reset(d); continue; end
            for (int i = 0; i < 8; i++) old[i] = mem[d][i];
            maxv = (longint'(1) << (w_d[d] - 1)) - 1;
            minv = -(longint'(1) << (w_d[d] - 1));
            m_rdv[d] = rd_en;
            if (rd_en) m_rdd[d] = old[rd_a];
            sat_ev = 0;
            if (m_busy[d]) begin
                drop_ev = acc_en | comp_en;
                if (rd_en && rd_clr) mem[d][rd_a] = 0;
                mem[d][m_cnt[d]] = 0;
                if (m_cnt[d] == 7) begin
                    m_busy[d] = 0; m_cnt[d] = 0; m_sat[d] = 0; m_drop[d] = drop_ev;
                end else begin
                    m_cnt[d]++; m_drop[d] |= drop_ev;
                end
            end else begin
                if (rd_en && rd_clr) mem[d][rd_a] = 0;
                if (acc_en && !(comp_en && comp_a == acc_a)) begin
                    base = (rd_en && rd_clr && rd_a == acc_a) ? 0 : old[acc_a];
                    s = base + sx(psum_v, w_d[d]);
                    if (s > maxv || s < minv) begin
                        sat_ev = 1;
                        if (sat_d[d]) s = (s > maxv) ? maxv : minv;
                        else if (s > maxv) s -= (longint'(1) << w_d[d]);
                        else s += (longint'(1) << w_d[d]);
                    end
                    mem[d][acc_a] = s;
                end
                if (comp_en) mem[d][comp_a] = sx(comp_v, cw_d[d]);
                if (clr_all) begin m_busy[d] = 1; m_cnt[d] = 0; end
                m_sat[d] |= sat_ev;
            end
        end
    endtask

    task automatic chk_dut(input int d, input logic rv, input logic signed [63:0] rd,
                           input logic b, input logic s, input logic dr);
        chk($sformatf("d%0d_rd_valid", d), 64'(rv), 64'(m_rdv[d]));
        chk($sformatf("d%0d_rd_data", d), rd, m_rdd[d]);
        chk($sformatf("d%0d_busy", d), 64'(b), 64'(m_busy[d]));
        chk($sformatf("d%0d_sat_flag", d), 64'(s), 64'(m_sat[d]));
        chk($sformatf("d%0d_drop_flag", d), 64'(dr), 64'(m_drop[d]));
    endtask

    task automatic check_all();
        chk_dut(0, if_b.rd_valid, 64'(if_b.rd_data), if_b.busy, if_b.sat_flag, if_b.drop_flag);
        chk_dut(1, if_s.rd_valid, 64'(if_s.rd_data), if_s.busy, if_s.sat_flag, if_s.drop_flag);
        chk_dut(2, if_w.rd_valid, 64'(if_w.rd_data), if_w.busy, if_w.sat_flag, if_w.drop_flag);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        acc_en = 0; comp_en = 0; rd_en = 0; rd_clr = 0; clr_all = 0;
        acc_a = 0; comp_a = 0; rd_a = 0; psum_v = 0; comp_v = 0;
    endtask

    task automatic set_acc(input int a, input longint v);
        acc_en = 1; acc_a = 3'(a); psum_v = v;
    endtask

    task automatic set_comp(input int a, input longint v);
        comp_en = 1; comp_a = 3'(a); comp_v = v;
    endtask

    task automatic set_rd(input int a, input bit clr);
        rd_en = 1; rd_a = 3'(a); rd_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        int busy_len;
        longint tmp;
        idle_in();
        rst_n = 0;
        for (int d = 0; d < 3; d++) model_reset(d);
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;

        // preload -5 then accumulate 100, 200, -50
        set_comp(2, -5); tick();
        set_acc(2, 100); tick();
        set_acc(2, 200); tick();
        set_acc(2, -50); tick();
        set_rd(2, 0); tick();
        chk("t1_rd_245", 64'(if_b.rd_data), 245);
        chk("t1_rd_valid", 64'(if_b.rd_valid), 1);
        tick();
        chk("t1_rd_valid_low", 64'(if_b.rd_valid), 0);

        // 8-bit overflow: saturate vs wrap
        set_comp(0, 100); tick();
        set_acc(0, 50); tick();
        set_rd(0, 0); tick();
        chk("t2_sat8", 64'(if_s.rd_data), 127);
        chk("t2_wrap8", 64'(if_w.rd_data), -106);
        chk("t2_big", 64'(if_b.rd_data), 150);
        chk("t2_sat8_flag", 64'(if_s.sat_flag), 1);
        chk("t2_wrap8_flag", 64'(if_w.sat_flag), 1);

        // collisions
        set_comp(3, 7); set_acc(3, 1000); tick();
        set_acc(1, 11); set_comp(4, -3); tick();
        set_rd(3, 0); tick();
        chk("t3_preload_wins", 64'(if_b.rd_data), 7);
        set_rd(1, 0); tick();
        chk("t3_acc_other", 64'(if_b.rd_data), 11);
        set_rd(4, 0); tick();
        chk("t3_comp_other", 64'(if_b.rd_data), -3);

        // read-and-clear with same-cycle accumulate
        set_comp(5, 40); tick();
        set_rd(5, 1); set_acc(5, 9); tick();
        chk("t4_rd_before_clr", 64'(if_b.rd_data), 40);
        set_rd(5, 0); tick();
        chk("t4_clr_then_add", 64'(if_b.rd_data), 9);

        // bulk clear with all entries nonzero
        for (int i = 0; i < 8; i++) begin set_comp(i, i + 1); tick(); end
        clr_all = 1; tick();
        busy_len = if_b.busy ? 1 : 0;
        for (int k = 1; k <= 20 && if_b.busy; k++) begin
            if (k == 2) set_rd(7, 0);
            if (k == 3) set_acc(6, 5);
            if (k == 4) clr_all = 1;
            tick();
            if (k == 2) chk("t5_sweep_rd", 64'(if_b.rd_data), 8);
            if (k == 3) chk("t5_drop_rise", 64'(if_b.drop_flag), 1);
            if (if_b.busy) busy_len++;
        end
        chk("t5_busy_len", busy_len, 8);
        chk("t5_drop_cleared", 64'(if_b.drop_flag), 0);
        chk("t5_sat_cleared", 64'(if_s.sat_flag), 0);
        for (int i = 0; i < 8; i++) begin
            set_rd(i, 0); tick();
            chk($sformatf("t5_zero_%0d", i), 64'(if_b.rd_data), 0);
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) != 0) psum_v = {$urandom(), $urandom()};
                else begin tmp = longint'($urandom_range(0, 400)) - 200; psum_v = tmp; end
                acc_en = 1; acc_a = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 4) == 0) begin
                tmp = longint'($urandom_range(0, 16383)) - 8192;
                set_comp($urandom_range(0, 7), tmp);
            end
            if ($urandom_range(0, 1) != 0) set_rd($urandom_range(0, 7), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) clr_all = 1;
            tick();
        end

        // async reset in the middle of a sweep
        for (int i = 0; i < 8; i++) begin set_comp(i, 20 + i); tick(); end
        set_acc(0, 120); tick();
        clr_all = 1; tick();
        set_acc(5, 1); tick();
        set_rd(6, 0); tick();
        #2;
        rst_n = 0;
        #1;
        chk("t6_busy_rst", 64'(if_b.busy), 0);
        chk("t6_sat_rst", 64'(if_s.sat_flag), 0);
        chk("t6_drop_rst", 64'(if_b.drop_flag), 0);
        chk("t6_rdv_rst", 64'(if_b.rd_valid), 0);
        chk("t6_rdd_rst", 64'(if_b.rd_data), 0);
        for (int d = 0; d < 3; d++) model_reset(d);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            set_rd(i, 0); tick();
            chk($sformatf("t6_zero_%0d", i), 64'(if_w.rd_data), 0);
        end
        set_comp(1, 3); tick();
        chk("t6_idle_no_drop", 64'(if_b.drop_flag), 0);
        set_rd(1, 0); tick();
        chk("t6_idle_write", 64'(if_b.rd_data), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
